// File: rtl/doy_pkg.sv
// Shared types, month table and leap-year helper for the day-of-year arbiter.
package doy_pkg;

    typedef struct packed {
        logic [5:0]  day;
        logic [3:0]  month;
        logic [10:0] year;
    } date_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Non-leap month lengths; February gets its extra day from is_leap().
    localparam logic [4:0] DAYS_IN_MONTH [1:12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Gregorian rule; year 0 is divisible by 400 and therefore leap.
    function automatic logic is_leap(input logic [10:0] year);
        return ((year % 11'd4) == 11'd0) &&
               (((year % 11'd100) != 11'd0) || ((year % 11'd400) == 11'd0));
    endfunction

endpackage

// File: rtl/day_of_year_calc.sv
// Combinational day-of-year calculator: cumulative days before the month,
// plus the day of month, plus one after February in leap years.
// Months outside 1..12 give an unspecified (but defined) result.
module day_of_year_calc
    import doy_pkg::*;
(
    input  logic [5:0]  day,
    input  logic [3:0]  month,
    input  logic [10:0] year,
    output logic [8:0]  day_of_year
);

    logic [8:0] days_before;
    logic       leap_adj;

    // Cumulative day count at the start of each month plus leap correction.
    always_comb begin
        days_before = 9'd0;
        case (month)
            4'd1:    days_before = 9'd0;
            4'd2:    days_before = 9'd31;
            4'd3:    days_before = 9'd59;
            4'd4:    days_before = 9'd90;
            4'd5:    days_before = 9'd120;
            4'd6:    days_before = 9'd151;
            4'd7:    days_before = 9'd181;
            4'd8:    days_before = 9'd212;
            4'd9:    days_before = 9'd243;
            4'd10:   days_before = 9'd273;
            4'd11:   days_before = 9'd304;
            4'd12:   days_before = 9'd334;
            default: days_before = 9'd0;
        endcase
        leap_adj    = is_leap(year) && (month > 4'd2) && (month <= 4'd12);
        day_of_year = days_before + {3'b000, day} + {8'b0000_0000, leap_adj};
    end

endmodule

// File: rtl/doy_rr_picker.sv
// Round-robin priority select: first asserted valid searching upward from
// last_grant+1 with wrap-around. Purely combinational.
module doy_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk the N_REQ candidates in rotated order, keep the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/doy_calc_arbiter.sv
// Shares one day_of_year_calc between N_REQ requesters. One transaction in
// flight: accept (IDLE) -> registered compute (CALC) -> hold response (RESP).
// Optional date range checking is enabled by defining DOY_RANGE_CHECK_EN;
// without it rsp_error is tied low and no checker exists.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// CALC  | captured date drives the calculator; result registered
// RESP  | response presented until rsp_ready, then pointer advances
module doy_calc_arbiter
    import doy_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [N_REQ*6-1:0]  req_day,
    input  logic [N_REQ*4-1:0]  req_month,
    input  logic [N_REQ*11-1:0] req_year,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [8:0]        rsp_day_of_year,
    output logic              rsp_error
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [N_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]   pick_id;
    logic              accept;
    date_t             sel_date;
    date_t             date_q;
    logic [ID_W-1:0]   id_q;
    logic [8:0]        result_q;
    logic [8:0]        calc_doy;

    doy_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_id   (pick_id)
    );

    day_of_year_calc u_calc (
        .day         (date_q.day),
        .month       (date_q.month),
        .year        (date_q.year),
        .day_of_year (calc_doy)
    );

    // Route the granted requester's date slices to the capture registers.
    always_comb begin
        sel_date.day   = req_day[6*int'(pick_id) +: 6];
        sel_date.month = req_month[4*int'(pick_id) +: 4];
        sel_date.year  = req_year[11*int'(pick_id) +: 11];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and accept; ready is held low while reset is asserted so no
    // handshake can appear to complete during reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready = pick_grant;
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid       = (state == RESP);
    assign rsp_id          = id_q;
    assign rsp_day_of_year = result_q;

`ifdef DOY_RANGE_CHECK_EN
    logic       date_bad;
    logic [5:0] day_limit;
    logic       error_q;

    // Month must be 1..12 and day 1..month length (Feb 29 only in leap years).
    always_comb begin
        date_bad  = 1'b1;
        day_limit = 6'd0;
        if ((date_q.month >= 4'd1) && (date_q.month <= 4'd12)) begin
            day_limit = {1'b0, DAYS_IN_MONTH[date_q.month]} +
                        {5'b00000, (date_q.month == 4'd2) && is_leap(date_q.year)};
            date_bad  = (date_q.day == 6'd0) || (date_q.day > day_limit);
        end
    end

    // Error flag is registered alongside the result in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 error_q <= 1'b0;
        else if (state == CALC)  error_q <= date_bad;
    end

    assign rsp_error = error_q;
`else
    assign rsp_error = 1'b0;
`endif

    // Capture request, register result, advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            date_q     <= '0;
            id_q       <= '0;
            result_q   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            if (accept) begin
                date_q <= sel_date;
                id_q   <= pick_id;
            end
            if (state == CALC) begin
`ifdef DOY_RANGE_CHECK_EN
                result_q <= date_bad ? 9'd0 : calc_doy;
`else
                result_q <= calc_doy;
`endif
            end
            if ((state == RESP) && rsp_ready) last_grant <= id_q;
        end
    end

endmodule

// File: tb/tb_doy_calc_arbiter.sv
// Scoreboard bench for doy_calc_arbiter: the driver issues requests, a
// monitor predicts grants and responses from calendar arithmetic and
// compares whenever the DUT presents them.
module tb_doy_calc_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ*6-1:0]  req_day;
    logic [N_REQ*4-1:0]  req_month;
    logic [N_REQ*11-1:0] req_year;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [8:0]        rsp_day_of_year;
    logic              rsp_error;

    doy_calc_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_day         (req_day),
        .req_month       (req_month),
        .req_year        (req_year),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_day_of_year (rsp_day_of_year),
        .rsp_error       (rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int doy;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;
    int   phase    = 0;

    // ---------------- reference calendar model ----------------
    function automatic bit leap_f(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim_f(input int m, input int y);
        case (m)
            1, 3, 5, 7, 8, 10, 12: return 31;
            4, 6, 9, 11:           return 30;
            2:                     return leap_f(y) ? 29 : 28;
            default:               return 0;
        endcase
    endfunction

    function automatic int ref_doy(input int d, input int m, input int y);
        int s;
        s = d;
        for (int k = 1; k < m; k++) s += dim_f(k, y);
        return s;
    endfunction

    function automatic int ref_err(input int d, input int m, input int y);
`ifdef DOY_RANGE_CHECK_EN
        return (m < 1 || m > 12 || d < 1 || d > dim_f(m, y)) ? 1 : 0;
`else
        return (d < 0 && m < 0 && y < 0) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int        m_ptr = N_REQ - 1;
    bit        m_busy = 1'b0;
    int        m_age = 0;
    int        m_rr = 0;
    int        m_prev_phase = -1;

    initial begin
        forever begin
            logic [N_REQ-1:0] exp_ready;
            int   pick;
            bit   exp_rv;
            @(negedge clk);
            if (phase != m_prev_phase) begin
                m_prev_phase = phase;
                m_rr = 0;
                if (phase == 9) begin
                    check("end_scoreboard_empty", sb.size(), 0);
                    check("end_idle", int'(m_busy), 0);
                end
            end
            if (rst) begin
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_id", rsp_id, 0);
                check("rst_rsp_doy", rsp_day_of_year, 0);
                check("rst_rsp_error", rsp_error, 0);
                check("rst_req_ready", req_ready, 0);
                sb.delete();
                m_busy = 1'b0;
                m_ptr  = N_REQ - 1;
            end else begin
                exp_ready = '0;
                pick = -1;
                if (!m_busy) begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        int j;
                        j = (m_ptr + k) % N_REQ;
                        if (pick < 0 && req_valid[j]) pick = j;
                    end
                end
                if (pick >= 0) exp_ready[pick] = 1'b1;
                check("req_ready", req_ready, exp_ready);
                exp_rv = m_busy && (m_age >= 2);
                check("rsp_valid", rsp_valid, exp_rv);
                if (rsp_valid && sb.size() > 0) begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_day_of_year", rsp_day_of_year, sb[0].doy);
                    check("rsp_error", rsp_error, sb[0].err);
                end
                if (rsp_valid && rsp_ready && phase == 4) begin
                    check("rr_order", rsp_id, m_rr);
                    m_rr = (m_rr + 1) % N_REQ;
                end
                if (pick >= 0) begin
                    exp_t e;
                    int d, m, y;
                    d = int'(req_day[6*pick +: 6]);
                    m = int'(req_month[4*pick +: 4]);
                    y = int'(req_year[11*pick +: 11]);
                    e.id  = pick;
                    e.err = ref_err(d, m, y);
                    e.doy = (e.err != 0) ? 0 : ref_doy(d, m, y);
                    sb.push_back(e);
                    m_ptr  = pick;
                    m_busy = 1'b1;
                    m_age  = 1;
                end else if (m_busy) begin
                    if (exp_rv && rsp_ready) begin
                        m_busy = 1'b0;
                        if (sb.size() > 0) void'(sb.pop_front());
                    end else begin
                        m_age++;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_req(input int i, input int d, input int m, input int y);
        req_day[6*i +: 6]    = 6'(d);
        req_month[4*i +: 4]  = 4'(m);
        req_year[11*i +: 11] = 11'(y);
        req_valid[i]         = 1'b1;
    endtask

    task automatic rand_date(input int i);
        int d, m, y;
        y = int'($urandom_range(0, 2047));
        m = int'($urandom_range(1, 12));
        d = int'($urandom_range(1, dim_f(m, y)));
`ifdef DOY_RANGE_CHECK_EN
        if ($urandom_range(0, 4) == 0) begin
            m = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 63));
        end
`endif
        req_day[6*i +: 6]    = 6'(d);
        req_month[4*i +: 4]  = 4'(m);
        req_year[11*i +: 11] = 11'(y);
    endtask

    // One clock: sample handshakes on the falling edge, update after the rise.
    task automatic step(output logic [N_REQ-1:0] acc);
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc[i]) begin
                case (mode)
                    1:       rand_date(i);
                    2:       begin rand_date(i); req_valid[i] = 1'($urandom_range(0, 1)); end
                    default: req_valid[i] = 1'b0;
                endcase
            end else if (mode == 2) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    rand_date(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (mode == 2) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_acc(input int i);
        logic [N_REQ-1:0] a;
        int cnt;
        cnt = 0;
        do begin
            step(a);
            cnt++;
            if (cnt > 40) begin
                $display("FAIL wait_acc timeout requester %0d", i);
                $fatal(1, "accept timeout");
            end
        end while (!a[i]);
    endtask

    task automatic drain(input int n);
        logic [N_REQ-1:0] a;
        repeat (n) step(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] a;
        int cnt, guard;
        rst       = 1'b1;
        req_valid = '0;
        req_day   = '0;
        req_month = '0;
        req_year  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        phase = 1;
        set_req(1, 1, 2, 2020);
        wait_acc(1);
        drain(4);

        phase = 2;
        set_req(3, 31, 12, 2020); wait_acc(3); drain(3);
        set_req(3, 1, 3, 1900);   wait_acc(3); drain(3);
        set_req(3, 1, 3, 2000);   wait_acc(3); drain(3);
        set_req(3, 1, 3, 0);      wait_acc(3); drain(4);

        phase = 4;
        mode = 1;
        for (int i = 0; i < N_REQ; i++) rand_date(i);
        req_valid = '1;
        cnt = 0;
        guard = 0;
        while (cnt < 8) begin
            step(a);
            cnt += $countones(a);
            guard++;
            if (guard > 100) begin
                $display("FAIL continuous phase timeout");
                $fatal(1, "timeout");
            end
        end
        req_valid = '0;
        mode = 0;
        drain(4);

        phase = 5;
        rsp_ready = 1'b0;
        set_req(1, 15, 6, 1999);
        set_req(2, 28, 2, 2100);
        wait_acc(1);
        drain(7);
        rsp_ready = 1'b1;
        wait_acc(2);
        drain(4);

        phase = 6;
`ifdef DOY_RANGE_CHECK_EN
        set_req(0, 29, 2, 2021); wait_acc(0); drain(3);
        set_req(0, 29, 2, 2024); wait_acc(0); drain(3);
        set_req(0, 1, 13, 2020); wait_acc(0); drain(3);
        set_req(0, 0, 5, 2020);  wait_acc(0); drain(3);
`endif
        set_req(2, 31, 12, 2047); wait_acc(2); drain(4);

        phase = 7;
        set_req(0, 10, 10, 1010); wait_acc(0); drain(4);
        set_req(1, 5, 5, 1555);
        wait_acc(1);
        rst = 1'b1;
        req_valid = '0;
        drain(2);
        rst = 1'b0;
        set_req(2, 3, 3, 333);
        set_req(0, 30, 11, 1984);
        wait_acc(0);
        wait_acc(2);
        drain(4);

        phase = 8;
        mode = 2;
        repeat (400) step(a);
        mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        drain(6);

        phase = 9;
        drain(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/doy_calc_arbiter.md
Name: doy_calc_arbiter

Overview:
Shares one combinational day-of-year calculator (`day_of_year_calc`) between N_REQ requesters. Each requester presents a date (day, month, year) with a valid/ready handshake. A round-robin arbiter grants one request at a time, registers the date, computes the result in a registered stage, and returns it on a single response channel tagged with the requester ID. The block sits between the date-producing clients and the shared calculator datapath.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_W, $clog2(N_REQ): width of the requester ID.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_day  in  N_REQ*6  packed day of month, slice i = [6i+5:6i].
- req_month  in  N_REQ*4  packed month, slice i = [4i+3:4i].
- req_year  in  N_REQ*11  packed year, slice i = [11i+10:11i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_day_of_year  out  9  result, 1..366.
- rsp_error  out  1  date out of range (optional feature only, else tied 0).

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. Round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, select the first asserted requester searching from last_grant+1 with wrap-around.
  - Assert req_ready for that requester only, combinationally, in the same cycle. The handshake completes on valid&&ready.
  - Capture day, month and year into date registers, capture the ID, then go to CALC.
  - If no requests are pending, stay in IDLE with req_ready all 0.
- CALC:
  - req_ready is all 0.
  - Drive the captured date into the calculator and register its output into the result register (plus error if enabled).
  - Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_day_of_year and rsp_error hold stable until rsp_ready.
  - On rsp_valid&&rsp_ready: last_grant <= rsp_id, rsp_valid drops the next cycle, go to IDLE.
  - req_ready stays 0 in RESP; there is no overlap with the next accept.
- Timing:
  - Latency: accept in cycle T, rsp_valid first high in T+2.
  - Minimum spacing is 3 cycles per transaction with rsp_ready tied high.
- Requester rules:
  - A requester must hold req_valid and its data stable until req_ready.
  - Deasserting req_valid before grant is allowed; that request is dropped without side effects.
- Arithmetic: the result is 9 bits. Leap years follow the Gregorian rule (divisible by 4, except centuries not divisible by 400). Year 0 counts as leap.
- Simultaneous events: all requesters valid rotates the grant strictly 0,1,2,3,0... A new request arriving while in RESP waits; it is not queued beyond the holding requester's own valid.
- Reset mid-operation: any in-flight transaction is discarded, no response is issued, and the pointer returns to N_REQ-1.

Optional Feature:
- Macro: DOY_RANGE_CHECK_EN.
- Defined:
  - In CALC, check month in 1..12 and day in 1..days_in_month, with February allowing 29 only in leap years.
  - On failure: rsp_error = 1 and rsp_day_of_year = 0. On success: rsp_error = 0.
- Undefined:
  - rsp_error is tied 0 and no checker logic is synthesized.
  - Out-of-range inputs give an unspecified rsp_day_of_year; the protocol and timing are unchanged.

Decomposition:
- Package doy_pkg:
  - typedef date_t = struct {day[5:0], month[3:0], year[10:0]}.
  - typedef state_t enum {IDLE, CALC, RESP}.
  - constant DAYS_IN_MONTH[1:12].
  - function is_leap(year).
- One sub-module: doy_rr_picker (combinational round-robin priority select). Inputs are the valid vector and last_grant; outputs are a one-hot grant and the grant ID.
- Instantiate the existing `day_of_year_calc` as the datapath; do not duplicate it.

Test Plan:
- Requester 1 sends day=1, month=2, year=2020, rsp_ready=1 -> rsp_valid at T+2 with rsp_id=1, rsp_day_of_year=32, rsp_error=0.
- Single requester sends 31/12/2020, then 1/3/1900, then 1/3/2000 -> results 366, 60, 61 in order.
- All 4 requesters hold valid continuously for 8 transactions -> rsp_id sequence 0,1,2,3,0,1,2,3, and req_ready is one-hot on each accept cycle only.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_day_of_year stay stable, req_ready stays all 0; after release the next grant follows round-robin order.
- With DOY_RANGE_CHECK_EN: 29/2/2021 -> rsp_error=1, rsp_day_of_year=0; 29/2/2024 -> rsp_error=0, result 60; month=13 -> rsp_error=1.
- rst asserted during CALC -> all outputs 0 immediately, no response for the aborted request; after release, requesters 2 and 0 both valid -> requester 0 is granted first.
